// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: FSM states and ALU unit-group codes.
// The ALU decoder reads alu_fun[3:2] as one of the FUN_* groups.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [1:0] FUN_ARITH = 2'b00;
  localparam logic [1:0] FUN_LOGIC = 2'b01;
  localparam logic [1:0] FUN_CMP   = 2'b10;
  localparam logic [1:0] FUN_SHIFT = 2'b11;

  function automatic logic [1:0] fun_group(input logic [3:0] fun);
    return fun[3:2];
  endfunction

endpackage

// File: rtl/alu_arb_if.sv
// Request, ALU-issue and response bundle between clients, arbiter and ALU.
// slave = arbiter side, master = environment (clients, ALU, consumer).
interface alu_arb_if #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32
);

  logic                     req0_valid;
  logic                     req0_ready;
  logic signed [DATA_W-1:0] req0_a;
  logic signed [DATA_W-1:0] req0_b;
  logic [3:0]               req0_fun;

  logic                     req1_valid;
  logic                     req1_ready;
  logic signed [DATA_W-1:0] req1_a;
  logic signed [DATA_W-1:0] req1_b;
  logic [3:0]               req1_fun;

  logic signed [DATA_W-1:0] alu_a;
  logic signed [DATA_W-1:0] alu_b;
  logic [3:0]               alu_fun;
  logic                     alu_en;
  logic [RES_W-1:0]         alu_result;
  logic                     alu_out_valid;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_id;
  logic [RES_W-1:0]         rsp_result;
  logic                     rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fun,
    input  req1_valid, req1_a, req1_b, req1_fun,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_fun, alu_en,
    input  alu_result, alu_out_valid,
    output rsp_valid, rsp_id, rsp_result, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_fun,
    output req1_valid, req1_a, req1_b, req1_fun,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_fun, alu_en,
    output alu_result, alu_out_valid,
    input  rsp_valid, rsp_id, rsp_result, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the side not granted last time wins.
module rr_arb2 (
  input  logic v0_i,
  input  logic v1_i,
  input  logic last_i,
  output logic gnt_o,
  output logic id_o
);

  assign gnt_o = v0_i | v1_i;
  assign id_o  = (v0_i & v1_i) ? ~last_i : v1_i;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer for two clients sharing one registered ALU.
// Optional WAIT watchdog enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 15
) (
  input logic      CLK,
  input logic      RST,
  alu_arb_if.slave bus
);

  state_e state_q, state_d;

  logic                     ptr_q;
  logic                     id_q;
  logic                     en_q;
  logic                     vld_q;
  logic signed [DATA_W-1:0] a_q;
  logic signed [DATA_W-1:0] b_q;
  logic [3:0]               fun_q;
  logic [RES_W-1:0]         res_q;

  logic gnt;
  logic gnt_id;
  logic accept;
  logic alu_done;
  logic tmo;
  logic rsp_hs;

  if (TIMEOUT < 1) begin : g_tmo_chk
    $error("TIMEOUT must be at least 1");
  end

  rr_arb2 u_pick (
    .v0_i   (bus.req0_valid),
    .v1_i   (bus.req1_valid),
    .last_i (ptr_q),
    .gnt_o  (gnt),
    .id_o   (gnt_id)
  );

  assign accept   = (state_q == S_IDLE) && gnt;
  assign alu_done = (state_q == S_WAIT) && bus.alu_out_valid;
  assign rsp_hs   = (state_q == S_RESP) && bus.rsp_ready;

  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept && gnt_id;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // cnt_q counts WAIT cycles already spent without a result
  assign tmo = (state_q == S_WAIT) && !bus.alu_out_valid &&
               (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (rsp_hs) begin
        err_q <= 1'b0;
      end else if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign tmo         = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (gnt) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.alu_out_valid || tmo) state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= 1'b1;
      id_q  <= 1'b0;
      en_q  <= 1'b0;
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      fun_q <= '0;
      res_q <= '0;
    end else begin
      en_q <= accept;
      if (accept) begin
        ptr_q <= gnt_id;
        id_q  <= gnt_id;
        a_q   <= gnt_id ? bus.req1_a   : bus.req0_a;
        b_q   <= gnt_id ? bus.req1_b   : bus.req0_b;
        fun_q <= gnt_id ? bus.req1_fun : bus.req0_fun;
      end
      if (alu_done) begin
        res_q <= bus.alu_result;
      end else if (tmo) begin
        res_q <= '0;
      end
      if (alu_done || tmo) begin
        vld_q <= 1'b1;
      end else if (rsp_hs) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_fun    = fun_q;
  assign bus.alu_en     = en_q;
  assign bus.rsp_valid  = vld_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter against a transaction-level model.
// Watchdog cases are selected by ALU_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int DW  = 16;
  localparam int RW  = 32;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_arb_if #(.DATA_W(DW), .RES_W(RW)) bus ();

  alu_arbiter #(.DATA_W(DW), .RES_W(RW), .TIMEOUT(TMO)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                   v;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    logic [3:0]           f;
  } req_t;

  req_t pend[2];
  bit   last_gnt;
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] alu_ref(input logic signed [DW-1:0] a,
                                            input logic signed [DW-1:0] b,
                                            input logic [3:0] f);
    logic signed [RW-1:0] r;
    case (f[3:2])
      2'b00:   r = f[0] ? a - b : a + b;
      2'b01:   r = a & b;
      2'b10:   r = (a < b) ? 1 : 0;
      default: r = a <<< b[3:0];
    endcase
    return r;
  endfunction

  function automatic req_t new_req(input bit v);
    req_t r;
    r.v = v;
    r.a = DW'($urandom);
    r.b = DW'($urandom);
    r.f = 4'($urandom);
    return r;
  endfunction

  task automatic drive();
    bus.req0_valid = pend[0].v;
    bus.req0_a     = pend[0].a;
    bus.req0_b     = pend[0].b;
    bus.req0_fun   = pend[0].f;
    bus.req1_valid = pend[1].v;
    bus.req1_a     = pend[1].a;
    bus.req1_b     = pend[1].b;
    bus.req1_fun   = pend[1].f;
  endtask

  task automatic check_zero(input string tag);
    check(tag, {bus.alu_a, bus.alu_b, bus.alu_fun, bus.alu_en,
                bus.rsp_valid, bus.rsp_id, bus.rsp_err}, '0);
    check({tag, "_res"}, bus.rsp_result, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.alu_out_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    pend[0].v = 1'b0;
    pend[1].v = 1'b0;
    drive();
    last_gnt = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    check("reset_rdy", {bus.req1_ready, bus.req0_ready}, 0);
    rst = 1'b0;
  endtask

  // d: ALU latency in WAIT cycles (0 = never), bp: RESP stall cycles
  task automatic run_op(input int d, input int bp, input bit both,
                        output int got_id);
    req_t w;
    int win;
    int waitn;
    bit to;
    logic [RW-1:0] exp_res;
    got_id = -1;
    @(negedge clk);
    check("idle_rsp", bus.rsp_valid, 0);
    check("idle_en", bus.alu_en, 0);
    if (!pend[0].v && !pend[1].v) pend[$urandom_range(0, 1)].v = 1'b1;
    drive();
    #1;
    if (pend[0].v && pend[1].v) win = last_gnt ? 0 : 1;
    else win = pend[1].v ? 1 : 0;
    check("ready0", bus.req0_ready, win == 0);
    check("ready1", bus.req1_ready, win == 1);
    w = pend[win];
    last_gnt = win[0];
    @(negedge clk);
    check("issue_en", bus.alu_en, 1);
    check("issue_a", bus.alu_a, w.a);
    check("issue_b", bus.alu_b, w.b);
    check("issue_fun", bus.alu_fun, w.f);
    pend[win] = new_req(both ? 1'b1 : 1'($urandom_range(0, 1)));
    drive();
    #1;
    check("issue_rdy", {bus.req1_ready, bus.req0_ready}, 0);
    waitn = d;
    to = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
    if (d == 0 || d > TMO) begin
      waitn = TMO;
      to = 1'b1;
    end
`endif
    exp_res = to ? '0 : alu_ref(w.a, w.b, w.f);
    for (int j = 1; j <= waitn; j++) begin
      @(negedge clk);
      check("wait_quiet", {bus.alu_en, bus.rsp_valid, bus.rsp_err}, 0);
      bus.alu_out_valid = !to && (j == d);
      bus.alu_result = (!to && j == d) ? exp_res : RW'($urandom);
      #1;
      check("wait_rdy", {bus.req1_ready, bus.req0_ready}, 0);
    end
    for (int k = 0; k <= bp; k++) begin
      @(negedge clk);
      bus.alu_out_valid = 1'b0;
      bus.alu_result = RW'($urandom);
      if (k == 0) got_id = int'(bus.rsp_id);
      check("rsp_valid", bus.rsp_valid, 1);
      check("rsp_id", bus.rsp_id, win);
      check("rsp_result", bus.rsp_result, exp_res);
      check("rsp_err", bus.rsp_err, to);
      bus.rsp_ready = (k == bp);
      #1;
      check("rsp_rdy", {bus.req1_ready, bus.req0_ready}, 0);
    end
  endtask

  int id;

  initial begin
    bus.alu_result = '0;
    pend[0] = new_req(1'b0);
    pend[1] = new_req(1'b0);
    do_reset();

    pend[0] = new_req(1'b1);
    pend[1] = new_req(1'b1);
    for (int i = 0; i < 4; i++) begin
      run_op(1, 0, 1'b1, id);
      check("tie_order", id, i % 2);
    end

    pend[0].v = 1'b1;
    pend[0].a = 16'sd5;
    pend[0].b = -16'sd3;
    pend[0].f = 4'b0000;
    pend[1].v = 1'b0;
    run_op(1, 0, 1'b0, id);

    pend[0] = new_req(1'b1);
    pend[1] = new_req(1'b1);
    run_op(2, 5, 1'b1, id);

    pend[0] = new_req(1'b1);
    pend[1] = new_req(1'b0);
    @(negedge clk);
    drive();
    #1;
    check("mid_rdy0", bus.req0_ready, 1);
    @(negedge clk);
    pend[0].v = 1'b0;
    drive();
    check("mid_en", bus.alu_en, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    bus.alu_out_valid = 1'b1;
    bus.alu_result = RW'($urandom);
    last_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.alu_out_valid = 1'b0;
      check("stray_rsp", bus.rsp_valid, 0);
    end
    pend[0] = new_req(1'b1);
    pend[1] = new_req(1'b1);
    run_op(1, 0, 1'b0, id);
    check("rst_tie", id, 0);

    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(1, 4), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), id);
    end

`ifdef ALU_ARB_TIMEOUT_EN
    run_op(0, 0, 1'b0, id);
    run_op(TMO, 1, 1'b0, id);
    run_op(TMO + 3, 0, 1'b0, id);
    run_op(2, 0, 1'b0, id);
`else
    run_op(101, 0, 1'b0, id);
    run_op(1, 0, 1'b0, id);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared signed ALU. It accepts operation requests (operands plus 4-bit ALU function) from two clients over valid/ready handshakes. It issues one operation at a time to the ALU, waits for the ALU's registered result, and returns it with a requester tag over a valid/ready response channel. It sits between the control logic and the ALU top, whose internal decoder consumes `alu_fun[3:2]` as the unit group (00 arith, 01 logic, 10 cmp, 11 shift).

## Interface
- `DATA_W`, 16: operand width (signed).
- `RES_W`, 32: ALU result width.
- `TIMEOUT`, 15: WAIT-state cycle limit (used only with the timeout feature).

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle (combinational).
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DATA_W  signed operands.
- `req0_fun` / `req1_fun`  in  4  ALU function code.
- `alu_a`, `alu_b`  out  DATA_W  registered operands to the ALU.
- `alu_fun`  out  4  registered function code to the ALU.
- `alu_en`  out  1  one-cycle issue strobe.
- `alu_result`  in  RES_W  ALU output.
- `alu_out_valid`  in  1  ALU result valid.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester index of the response.
- `rsp_result`  out  RES_W  captured result.
- `rsp_err`  out  1  timeout flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if either valid is high, the grant goes to the winner and its `reqN_ready` is 1 that cycle. Operands, function and id are latched. Next state is ISSUE. Both ready outputs are 0 in every other state.
- Arbitration: with a single requester, that requester wins. With both, the requester not granted last time wins. The last-grant pointer resets to 1, so req0 wins the first tie.
- ISSUE: `alu_en`=1 for exactly one cycle, with `alu_a`/`alu_b`/`alu_fun` stable from the latched values. Next state is WAIT. `alu_out_valid` is ignored in ISSUE.
- WAIT: on `alu_out_valid`=1, capture `alu_result` into `rsp_result`, set `rsp_err`=0, and go to RESP.
- RESP: `rsp_valid`=1. `rsp_id`, `rsp_result` and `rsp_err` are held until `rsp_valid & rsp_ready`, then the FSM goes to IDLE. No new request is accepted in the handshake cycle.
- `alu_a`, `alu_b` and `alu_fun` hold their last issued values until the next grant. The block passes `alu_fun` through unmodified; codes are not checked.

## Timing
- Reset values: FSM=IDLE, pointer=1, and `alu_a`, `alu_b`, `alu_fun`, `alu_en`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_err`=0.
- Cycle 0 is the accept cycle (valid & ready).
- Cycle 1: `alu_en`=1.
- Cycle 2, earliest: `alu_out_valid` is sampled.
- Cycle 3, earliest: `rsp_valid`=1.
- Maximum throughput is one operation per 4 cycles with zero response backpressure.
- `rsp_ready` held high before `rsp_valid` rises: the handshake completes in the first RESP cycle.
- `RST` asserted in any state returns all state and outputs to reset values immediately. The in-flight operation is dropped with no response, and a later stray `alu_out_valid` in IDLE is ignored.
- All outputs except `reqN_ready` are registered.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT+1) runs in WAIT, cleared on WAIT entry.
  - If it reaches TIMEOUT without `alu_out_valid`, the FSM goes to RESP with `rsp_result`=0 and `rsp_err`=1.
  - If `alu_out_valid` arrives in the same cycle the count reaches TIMEOUT, the valid result wins and `rsp_err`=0.
- Not defined: no counter is built, `rsp_err` is tied to 0, and WAIT lasts indefinitely.

## Structure
- Package `alu_arb_pkg`:
  - FSM state enum.
  - Unit-group constants `FUN_ARITH`=2'b00, `FUN_LOGIC`=2'b01, `FUN_CMP`=2'b10, `FUN_SHIFT`=2'b11, shared with the ALU decoder.
- Sub-module `rr_arb2`: combinational two-way round-robin picker taking two valids and the pointer, returning the grant index and a grant flag.
- The pointer register lives in `alu_arbiter`.

## Test plan
- Reset, then req0 only with a=5, b=-3, fun=4'b0000, and the ALU model returning 2 after 1 cycle:
  - `alu_en` is high in cycle 1 with `alu_a`=5, `alu_b`=-3.
  - The response appears in cycle 3 with id=0, result=2, err=0.
- Both requesters valid continuously for 4 operations: grant order is 0,1,0,1 and `rsp_id` follows the same sequence.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_valid`, `rsp_id` and `rsp_result` stay stable.
  - Both ready outputs stay 0.
  - The FSM returns to IDLE the cycle after `rsp_ready` rises.
- Assert `RST` during WAIT, then release.
  - All outputs return to 0.
  - A late `alu_out_valid` produces no response.
  - The next tie grants req0.
- With `ALU_ARB_TIMEOUT_EN`, TIMEOUT=15, and the ALU model never asserting valid:
  - `rsp_valid` rises 15 cycles after WAIT entry with result=0 and err=1.
  - Repeat with valid arriving on the 15th cycle: err=0.
- Without the macro: `rsp_err` stays 0 and WAIT holds for 100 cycles without a response.
